// File: rtl/dds_param_ctrl_if.sv
// dds_param_ctrl_if -- key input / parameter-transfer bundle for dds_param_ctrl.
//
// Signals:
//   key_flag   [3:0]  debounced single-cycle key pulses
//                     [0] wave next, [1] freq up, [2] freq down, [3] sweep toggle
//   upd_rdy           DDS core accepts the presented parameter set
//   wave_sel   [3:0]  one-hot waveform select presented to the core
//   freq_word  [31:0] frequency control word presented to the core
//   upd_vld           a parameter set is pending transfer
//   sweep_busy        sweep engine is running
//
// Modports:
//   master  -- the controller (drives the parameter set and upd_vld)
//   slave   -- the key source / DDS core side
interface dds_param_ctrl_if;
  logic [3:0]  key_flag;
  logic        upd_rdy;
  logic [3:0]  wave_sel;
  logic [31:0] freq_word;
  logic        upd_vld;
  logic        sweep_busy;

  modport master (
    input  key_flag,
    input  upd_rdy,
    output wave_sel,
    output freq_word,
    output upd_vld,
    output sweep_busy
  );

  modport slave (
    output key_flag,
    output upd_rdy,
    input  wave_sel,
    input  freq_word,
    input  upd_vld,
    input  sweep_busy
  );
endinterface

// File: rtl/dds_param_ctrl.sv
// dds_param_ctrl -- key-driven parameter controller for a DDS core.
//
// Keys edit a working copy of the waveform select and frequency word.
// Any real edit marks the working set dirty; a dirty set is copied to the
// outputs and offered to the DDS core with a valid/ready handshake.
// Edits made while a transfer is pending coalesce into one later transfer
// carrying the latest values.
//
// Optional feature: define DDS_SWEEP_EN to build the frequency sweep engine
// (key_flag[3] toggles an up/down sweep that steps every DWELL_MAX+1 cycles
// and reverses at FW_MIN/FW_MAX). Without it key_flag[3] is ignored and
// sweep_busy is tied low.
//
// Ports:
//   sys_clk  clock, all logic on the rising edge
//   sys_rst  asynchronous active-high reset
//   bus      dds_param_ctrl_if.master (key_flag, upd_rdy in;
//            wave_sel, freq_word, upd_vld, sweep_busy out)
module dds_param_ctrl #(
  parameter logic [31:0] FW_INIT   = 32'd42_950,
  parameter logic [31:0] FW_STEP   = 32'd4_295,
  parameter logic [31:0] FW_MIN    = 32'd4_295,
  parameter logic [31:0] FW_MAX    = 32'd429_497,
  parameter logic [23:0] DWELL_MAX = 24'd4_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  dds_param_ctrl_if.master bus
);

  localparam logic [3:0] WAVE_RST = 4'b0001;

  // Saturating step arithmetic, done in 33 bits so nothing wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] fw);
    logic [32:0] s;
    s = {1'b0, fw} + {1'b0, FW_STEP};
    if (s > {1'b0, FW_MAX}) return FW_MAX;
    return s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] fw);
    logic [32:0] d;
    d = {1'b0, fw} - {1'b0, FW_STEP};
    if (d[32] || (d[31:0] < FW_MIN)) return FW_MIN;
    return d[31:0];
  endfunction

  logic [3:0]  wave_w, wave_nxt;
  logic [31:0] fw_w, fw_nxt;
  logic [31:0] fw_add, fw_sub;
  logic        dirty;
  logic        change;
  logic        issue;
  logic [3:0]  wave_sel_q;
  logic [31:0] freq_word_q;
  logic        upd_vld_q;

  // Sweep control seen by the datapath.
  logic        toggle;
  logic        sweep_on;
  logic        step_up;
  logic        step_dn;

  assign fw_add = sat_add(fw_w);
  assign fw_sub = sat_sub(fw_w);

`ifdef DDS_SWEEP_EN
  typedef enum logic [1:0] {IDLE, SWP_UP, SWP_DN} sweep_t;

  sweep_t      state, state_nxt;
  logic [23:0] dwell, dwell_nxt;

  assign toggle = bus.key_flag[3];

  // Sweep state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      dwell <= dwell_nxt;
    end
  end

  // Sweep next-state logic; the toggle key wins over a same-cycle step.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    case (state)
      IDLE: begin
        if (toggle) begin
          state_nxt = SWP_UP;
          dwell_nxt = '0;
        end
      end
      SWP_UP, SWP_DN: begin
        if (toggle) begin
          state_nxt = IDLE;
          dwell_nxt = '0;
        end else if (dwell == DWELL_MAX) begin
          dwell_nxt = '0;
          // Reverse when this step lands on (or clamps to) a bound.
          if (state == SWP_UP && fw_add == FW_MAX) state_nxt = SWP_DN;
          if (state == SWP_DN && fw_sub == FW_MIN) state_nxt = SWP_UP;
        end else begin
          dwell_nxt = dwell + 24'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dwell_nxt = '0;
      end
    endcase
  end

  // Sweep outputs
  always_comb begin
    sweep_on = (state != IDLE);
    step_up  = (state == SWP_UP) && !toggle && (dwell == DWELL_MAX);
    step_dn  = (state == SWP_DN) && !toggle && (dwell == DWELL_MAX);
  end
`else
  logic        unused_toggle_key;
  logic [23:0] unused_dwell_max;

  assign unused_toggle_key = bus.key_flag[3];
  assign unused_dwell_max  = DWELL_MAX;
  assign toggle   = 1'b0;
  assign sweep_on = 1'b0;
  assign step_up  = 1'b0;
  assign step_dn  = 1'b0;
`endif

  // Working-set update. One key per cycle, highest index first; the freq
  // keys are masked out while sweeping so wave-next still gets through.
  always_comb begin
    wave_nxt = wave_w;
    fw_nxt   = fw_w;
    if (step_up)      fw_nxt = fw_add;
    else if (step_dn) fw_nxt = fw_sub;
    if (!toggle) begin
      if (bus.key_flag[2] && !sweep_on)      fw_nxt   = fw_sub;
      else if (bus.key_flag[1] && !sweep_on) fw_nxt   = fw_add;
      else if (bus.key_flag[0])              wave_nxt = {wave_w[2:0], wave_w[3]};
    end
    // A saturated no-op is not a change.
    change = (wave_nxt != wave_w) || (fw_nxt != fw_w);
  end

  // Issue when dirty and the output slot is free or being accepted now.
  assign issue = dirty && (!upd_vld_q || bus.upd_rdy);

  // Working registers and transfer handshake
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wave_w      <= WAVE_RST;
      fw_w        <= FW_INIT;
      dirty       <= 1'b0;
      wave_sel_q  <= WAVE_RST;
      freq_word_q <= FW_INIT;
      upd_vld_q   <= 1'b0;
    end else begin
      wave_w <= wave_nxt;
      fw_w   <= fw_nxt;
      // A change landing in the issue cycle stays dirty for the next issue.
      dirty  <= change || (dirty && !issue);
      if (issue) begin
        wave_sel_q  <= wave_w;
        freq_word_q <= fw_w;
        upd_vld_q   <= 1'b1;
      end else if (upd_vld_q && bus.upd_rdy) begin
        upd_vld_q <= 1'b0;
      end
    end
  end

  assign bus.wave_sel   = wave_sel_q;
  assign bus.freq_word  = freq_word_q;
  assign bus.upd_vld    = upd_vld_q;
  assign bus.sweep_busy = sweep_on;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// tb_dds_param_ctrl -- directed self-checking bench for dds_param_ctrl.
// DUT built with FW_INIT=500, FW_STEP=100, FW_MIN=100, FW_MAX=1000,
// DWELL_MAX=3. Sweep scenarios compile only with DDS_SWEEP_EN.
module tb_dds_param_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  dds_param_ctrl_if bus ();

  dds_param_ctrl #(
    .FW_INIT   (32'd500),
    .FW_STEP   (32'd100),
    .FW_MIN    (32'd100),
    .FW_MAX    (32'd1000),
    .DWELL_MAX (24'd3)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.key_flag = 4'b0000;
    bus.upd_rdy  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive a one-cycle key pulse; returns right after the pulse cycle's edge.
  task automatic pulse(input logic [3:0] k);
    @(negedge clk);
    bus.key_flag = k;
    @(negedge clk);
    bus.key_flag = 4'b0000;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.key_flag = 4'b0000;
    bus.upd_rdy  = 1'b0;
    @(negedge clk);
    total++;
    if (bus.wave_sel !== 4'b0001) begin
      bad++; $display("FAIL reset_wave: got %b want 0001", bus.wave_sel);
    end
    total++;
    if (bus.freq_word !== 32'd500) begin
      bad++; $display("FAIL reset_freq: got %0d want 500", bus.freq_word);
    end
    total++;
    if (bus.upd_vld !== 1'b0) begin
      bad++; $display("FAIL reset_vld: got %b want 0", bus.upd_vld);
    end
    total++;
    if (bus.sweep_busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", bus.sweep_busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.upd_vld !== 1'b0) begin
      bad++; $display("FAIL reset_release_vld: got %b want 0", bus.upd_vld);
    end
  endtask

  task automatic test_freq_up;
    logic [31:0] exp_fw [5];
    logic seen;
    exp_fw = '{32'd600, 32'd700, 32'd800, 32'd900, 32'd1000};
    do_reset();
    bus.upd_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(4'b0010);
      @(negedge clk);
      total++;
      if (bus.upd_vld !== 1'b1 || bus.freq_word !== exp_fw[i]) begin
        bad++;
        $display("FAIL freq_up[%0d]: got vld=%b fw=%0d want vld=1 fw=%0d",
                 i, bus.upd_vld, bus.freq_word, exp_fw[i]);
      end
      @(negedge clk);
      total++;
      if (bus.upd_vld !== 1'b0) begin
        bad++; $display("FAIL freq_up_drop[%0d]: got vld=%b want 0", i, bus.upd_vld);
      end
    end
    pulse(4'b0010);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.upd_vld === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || bus.freq_word !== 32'd1000) begin
      bad++;
      $display("FAIL freq_up_sat: got vld_seen=%b fw=%0d want 0 fw=1000", seen, bus.freq_word);
    end
  endtask

  task automatic test_freq_down;
    logic [31:0] exp_fw [4];
    logic seen;
    exp_fw = '{32'd400, 32'd300, 32'd200, 32'd100};
    do_reset();
    bus.upd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse(4'b0100);
      @(negedge clk);
      total++;
      if (bus.upd_vld !== 1'b1 || bus.freq_word !== exp_fw[i]) begin
        bad++;
        $display("FAIL freq_dn[%0d]: got vld=%b fw=%0d want vld=1 fw=%0d",
                 i, bus.upd_vld, bus.freq_word, exp_fw[i]);
      end
      @(negedge clk);
    end
    pulse(4'b0100);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.upd_vld === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || bus.freq_word !== 32'd100) begin
      bad++;
      $display("FAIL freq_dn_sat: got vld_seen=%b fw=%0d want 0 fw=100", seen, bus.freq_word);
    end
  endtask

  task automatic test_priority;
    do_reset();
    bus.upd_rdy = 1'b1;
    pulse(4'b0011);
    @(negedge clk);
    total++;
    if (bus.upd_vld !== 1'b1 || bus.freq_word !== 32'd600 || bus.wave_sel !== 4'b0001) begin
      bad++;
      $display("FAIL prio_up_wave: got vld=%b fw=%0d wave=%b want 1 600 0001",
               bus.upd_vld, bus.freq_word, bus.wave_sel);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.upd_vld !== 1'b0 || bus.wave_sel !== 4'b0001) begin
      bad++;
      $display("FAIL prio_wave_dropped: got vld=%b wave=%b want 0 0001", bus.upd_vld, bus.wave_sel);
    end
    // Down outranks up: 600 - 100.
    pulse(4'b0110);
    @(negedge clk);
    total++;
    if (bus.freq_word !== 32'd500) begin
      bad++; $display("FAIL prio_dn_over_up: got fw=%0d want 500", bus.freq_word);
    end
  endtask

  task automatic test_wave_rotate;
    logic [3:0] exp_w [4];
    exp_w = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.upd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse(4'b0001);
      @(negedge clk);
      total++;
      if (bus.upd_vld !== 1'b1 || bus.wave_sel !== exp_w[i]) begin
        bad++;
        $display("FAIL wave_rot[%0d]: got vld=%b wave=%b want vld=1 wave=%b",
                 i, bus.upd_vld, bus.wave_sel, exp_w[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_coalesce;
    do_reset();
    bus.upd_rdy = 1'b0;
    pulse(4'b0001);
    @(negedge clk);
    total++;
    if (bus.upd_vld !== 1'b1 || bus.wave_sel !== 4'b0010) begin
      bad++;
      $display("FAIL coal_first: got vld=%b wave=%b want 1 0010", bus.upd_vld, bus.wave_sel);
    end
    bus.key_flag = 4'b0001;
    @(negedge clk);
    bus.key_flag = 4'b0000;
    @(negedge clk);
    total++;
    if (bus.upd_vld !== 1'b1 || bus.wave_sel !== 4'b0010) begin
      bad++;
      $display("FAIL coal_hold: got vld=%b wave=%b want 1 0010", bus.upd_vld, bus.wave_sel);
    end
    bus.upd_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (bus.upd_vld !== 1'b1 || bus.wave_sel !== 4'b0100) begin
      bad++;
      $display("FAIL coal_reload: got vld=%b wave=%b want 1 0100", bus.upd_vld, bus.wave_sel);
    end
    @(negedge clk);
    total++;
    if (bus.upd_vld !== 1'b0 || bus.freq_word !== 32'd500) begin
      bad++;
      $display("FAIL coal_done: got vld=%b fw=%0d want 0 500", bus.upd_vld, bus.freq_word);
    end
  endtask

`ifdef DDS_SWEEP_EN
  task automatic test_sweep;
    logic [31:0] exp_fw [11];
    logic [31:0] prev;
    int n;
    int t;
    int last_t;
    exp_fw = '{32'd1000, 32'd900, 32'd800, 32'd700, 32'd600, 32'd500,
               32'd400, 32'd300, 32'd200, 32'd100, 32'd200};
    do_reset();
    bus.upd_rdy = 1'b1;
    repeat (4) begin
      pulse(4'b0010);
      repeat (3) @(negedge clk);
    end
    total++;
    if (bus.freq_word !== 32'd900) begin
      bad++; $display("FAIL sweep_start_fw: got %0d want 900", bus.freq_word);
    end
    prev = bus.freq_word;
    pulse(4'b1000);
    total++;
    if (bus.sweep_busy !== 1'b1) begin
      bad++; $display("FAIL sweep_busy_on: got %b want 1", bus.sweep_busy);
    end
    n = 0; t = 0; last_t = 0;
    while (n < 11 && t < 80) begin
      @(negedge clk);
      t++;
      if (bus.freq_word !== prev) begin
        prev = bus.freq_word;
        total++;
        if (bus.freq_word !== exp_fw[n]) begin
          bad++; $display("FAIL sweep_val[%0d]: got %0d want %0d", n, bus.freq_word, exp_fw[n]);
        end
        if (n > 0) begin
          total++;
          if (t - last_t !== 4) begin
            bad++; $display("FAIL sweep_period[%0d]: got %0d cycles want 4", n, t - last_t);
          end
        end
        last_t = t;
        n++;
      end
    end
    total++;
    if (n !== 11) begin
      bad++; $display("FAIL sweep_count: got %0d steps want 11 (timeout)", n);
    end
    pulse(4'b1000);
    total++;
    if (bus.sweep_busy !== 1'b0) begin
      bad++; $display("FAIL sweep_busy_off: got %b want 0", bus.sweep_busy);
    end
  endtask
`else
  task automatic test_no_sweep;
    logic busy_seen;
    logic vld_seen;
    do_reset();
    bus.upd_rdy = 1'b1;
    busy_seen = 1'b0;
    vld_seen  = 1'b0;
    @(negedge clk);
    bus.key_flag = 4'b1000;
    @(negedge clk);
    bus.key_flag = 4'b0000;
    repeat (8) begin
      if (bus.sweep_busy === 1'b1) busy_seen = 1'b1;
      if (bus.upd_vld === 1'b1) vld_seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (busy_seen !== 1'b0 || vld_seen !== 1'b0) begin
      bad++;
      $display("FAIL no_sweep: got busy_seen=%b vld_seen=%b want 0 0", busy_seen, vld_seen);
    end
  endtask
`endif

  task automatic test_reset_midop;
    logic vld_seen;
    do_reset();
    bus.upd_rdy = 1'b0;
    pulse(4'b0001);
`ifdef DDS_SWEEP_EN
    pulse(4'b1000);
    repeat (8) @(negedge clk);
`else
    pulse(4'b0010);
    repeat (2) @(negedge clk);
`endif
    total++;
    if (bus.upd_vld !== 1'b1) begin
      bad++; $display("FAIL midop_pending: got vld=%b want 1", bus.upd_vld);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.wave_sel !== 4'b0001 || bus.freq_word !== 32'd500 ||
        bus.upd_vld !== 1'b0 || bus.sweep_busy !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset: got wave=%b fw=%0d vld=%b busy=%b want 0001 500 0 0",
               bus.wave_sel, bus.freq_word, bus.upd_vld, bus.sweep_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.upd_rdy = 1'b1;
    vld_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.upd_vld === 1'b1 || bus.sweep_busy === 1'b1) vld_seen = 1'b1;
    end
    total++;
    if (vld_seen !== 1'b0) begin
      bad++; $display("FAIL midop_release: got activity=%b want 0", vld_seen);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.key_flag = 4'b0000;
    bus.upd_rdy  = 1'b0;
    test_reset();
    test_freq_up();
    test_freq_down();
    test_priority();
    test_wave_rotate();
    test_coalesce();
`ifdef DDS_SWEEP_EN
    test_sweep();
`else
    test_no_sweep();
`endif
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
